// File: rtl/mul_flop_syn_filt_if.sv
// Level-input bundle of the multi-channel synchronizer/debouncer: async levels in,
// filtered levels and edge pulses out.
interface mul_flop_syn_filt_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             sample_en;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_chg;

    modport master (
        output din,
        output sample_en,
        input  dout,
        input  rise,
        input  fall,
        input  any_chg
    );

    modport slave (
        input  din,
        input  sample_en,
        output dout,
        output rise,
        output fall,
        output any_chg
    );
endinterface

// File: rtl/mul_flop_syn_filt.sv
// Bank of WIDTH async level inputs: per-channel synchronizer chain, FILTER_LEN-sample
// debounce filter and registered rise/fall/any-change pulses, all in the clk domain.
module mul_flop_syn_filt #(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER_LEN  = 4,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_flop_syn_filt_if.slave   bus
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Counter step that cannot wrap, so a corrupted count can never alias to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0]                  s_p0;

    logic [WIDTH-1:0][CNT_W-1:0]       cnt_p1;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_nxt;
    logic [WIDTH-1:0]                  dout_p1;
    logic [WIDTH-1:0]                  dout_nxt;
    logic [WIDTH-1:0]                  rise_p1;
    logic [WIDTH-1:0]                  rise_nxt;
    logic [WIDTH-1:0]                  fall_p1;
    logic [WIDTH-1:0]                  fall_nxt;
    logic                              any_chg_p1;
    logic                              any_chg_nxt;

    // ---- stage p0: synchronizer chain, only sync_p0[0] ever samples din ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p0[k] <= RST_VAL;
            end
        end else begin
            sync_p0[0] <= bus.din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p0[k] <= sync_p0[k-1];
            end
        end
    end

    assign s_p0 = sync_p0[SYNC_STAGES-1];

    // ---- stage p1: debounce filter and edge pulses ----
    always_comb begin
        cnt_nxt  = cnt_p1;
        dout_nxt = dout_p1;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s_p0[i] == dout_p1[i]) begin
                cnt_nxt[i] = '0;
            end else if (bus.sample_en && (cnt_p1[i] == CNT_LAST)) begin
                dout_nxt[i] = s_p0[i];
                cnt_nxt[i]  = '0;
                rise_nxt[i] = s_p0[i];
                fall_nxt[i] = ~s_p0[i];
            end else if (bus.sample_en) begin
                cnt_nxt[i] = sat_inc(cnt_p1[i]);
            end
        end
        any_chg_nxt = |(rise_nxt | fall_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p1     <= '0;
            dout_p1    <= RST_VAL;
            rise_p1    <= '0;
            fall_p1    <= '0;
            any_chg_p1 <= 1'b0;
        end else begin
            cnt_p1     <= cnt_nxt;
            dout_p1    <= dout_nxt;
            rise_p1    <= rise_nxt;
            fall_p1    <= fall_nxt;
            any_chg_p1 <= any_chg_nxt;
        end
    end

    assign bus.dout    = dout_p1;
    assign bus.rise    = rise_p1;
    assign bus.fall    = fall_p1;
    assign bus.any_chg = any_chg_p1;

endmodule
